if_id_buffer: RTL and testbench



---
 rtl/if_id_buffer_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/if_id_buffer.sv | 70 +++++++
 tb/tb_if_id_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF->ID boundary: bus layout and queue entry width.
package if_id_buffer_pkg;
   localparam int IF_TO_ID_WD        = 97;
   localparam int IBUF_ENTRY_WD      = 96;
   localparam int IF_TO_ID_VALID_BIT = 96;
endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with clear; head is the combinational read of the oldest entry.
module fetch_fifo #(
   parameter  int WIDTH = 96,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full, empty, do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   // A push into a full queue is dropped rather than overwriting the head.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst_n && !clr) begin
         overflow_chk: assert (!(push && full));
      end
   end

endmodule

// File: rtl/if_id_buffer.sv
// Fetch->decode buffer: pairs each SRAM response with its request PC, queues it
// against decode stalls, drops flushed/replayed responses and requests fetch stall.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_WD = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [5:0]             stall,
   input  logic                   inst_sram_en,
   input  logic [PC_WD-1:0]       inst_sram_addr,
   input  logic [63:0]            inst_sram_rdata,
   output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   output logic                   stallreq_if
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                     req_q;
   logic [PC_WD-1:0]         pc_q;
   logic [31:0]              inst;
   logic                     resp_valid, nonempty, deq;
   logic [IBUF_ENTRY_WD-1:0] head;
   logic [CNT_W-1:0]         count;
   logic [CNT_W:0]           occ;
   logic                     unused_stall;

   // A request under stall[0] is a replay of a held PC; its response must not be kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= 1'b0;
         pc_q  <= '0;
      end else begin
         req_q <= inst_sram_en & ~stall[0] & ~flush;
         pc_q  <= inst_sram_addr;
      end
   end

   assign inst       = pc_q[2] ? inst_sram_rdata[63:32] : inst_sram_rdata[31:0];
   assign resp_valid = req_q & ~flush;
   assign nonempty   = (count != '0);
   assign deq        = nonempty & ~stall[1] & ~flush;

   fetch_fifo #(
      .WIDTH (IBUF_ENTRY_WD),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (resp_valid),
      .pop   (deq),
      .clr   (flush),
      .din   ({pc_q, inst}),
      .head  (head),
      .count (count)
   );

   // Registers only, and ignores a same-cycle dequeue: no loop through stall control.
   assign occ         = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
   assign stallreq_if = (occ >= (CNT_W+1)'(DEPTH));

   assign if_to_id_bus[IF_TO_ID_VALID_BIT]  = nonempty & ~flush;
   assign if_to_id_bus[IBUF_ENTRY_WD-1:0]   = nonempty ? head : '0;

   assign unused_stall = ^stall[5:2];

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: fetch stream, word select, replay, backpressure, flush, reset.
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [5:0]  stall;
   logic        inst_sram_en;
   logic [63:0] inst_sram_addr;
   logic [63:0] inst_sram_rdata;
   logic [96:0] if_to_id_bus;
   logic        stallreq_if;

   int          tests = 0;
   int          fails = 0;
   logic        fixed_en = 1'b0;
   logic [63:0] fixed_data = 64'hAAAA_BBBB_1111_2222;

   localparam logic [96:0] EMPTY = '0;
   localparam logic [63:0] B = 64'h8000_0000;

   if_id_buffer #(.DEPTH(4), .PC_WD(64)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .stall           (stall),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .if_to_id_bus    (if_to_id_bus),
      .stallreq_if     (stallreq_if)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f(input logic [63:0] pc);
      return pc[31:0] ^ 32'hDEAD_0000;
   endfunction

   function automatic logic [63:0] mk(input logic [63:0] a);
      logic [63:0] b;
      b = {a[63:3], 3'b000};
      return {f(b | 64'h4), f(b)};
   endfunction

   function automatic logic [96:0] ent(input logic [63:0] pc);
      return {1'b1, pc, f(pc)};
   endfunction

   task automatic tick();
      logic [63:0] a;
      a = inst_sram_addr;
      @(posedge clk);
      #1;
      inst_sram_rdata = fixed_en ? fixed_data : mk(a);
   endtask

   task automatic chk_bus(input string tag, input logic [96:0] exp);
      tests++;
      assert (if_to_id_bus === exp) else begin
         fails++;
         $error("FAIL %s: bus got %h want %h", tag, if_to_id_bus, exp);
      end
   endtask

   task automatic chk_vld(input string tag, input logic exp);
      tests++;
      assert (if_to_id_bus[96] === exp) else begin
         fails++;
         $error("FAIL %s: valid got %b want %b", tag, if_to_id_bus[96], exp);
      end
   endtask

   task automatic chk_sr(input string tag, input logic exp);
      tests++;
      assert (stallreq_if === exp) else begin
         fails++;
         $error("FAIL %s: stallreq_if got %b want %b", tag, stallreq_if, exp);
      end
   endtask

   // backpressure table, 13 cycles
   logic [63:0] bp_addr [13];
   logic        bp_en   [13];
   logic        bp_s0   [13];
   logic        bp_s1   [13];
   logic        bp_sr   [13];
   logic [63:0] bp_head [13];

   initial begin
      rst_n = 1'b0; flush = 1'b0; stall = '0;
      inst_sram_en = 1'b0; inst_sram_addr = '0; inst_sram_rdata = '0;
      #3;
      chk_bus("reset_bus", EMPTY);
      chk_sr("reset_sr", 1'b0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // straight-line fetch
      inst_sram_en = 1'b1; inst_sram_addr = B;
      chk_bus("s1_c0", EMPTY); chk_sr("s1_sr0", 1'b0); tick();
      inst_sram_addr = B + 4;
      chk_bus("s1_c1", EMPTY); chk_sr("s1_sr1", 1'b0); tick();
      inst_sram_addr = B + 8;
      chk_bus("s1_c2", ent(B)); chk_sr("s1_sr2", 1'b0); tick();
      inst_sram_en = 1'b0;
      chk_bus("s1_c3", ent(B + 4)); chk_sr("s1_sr3", 1'b0); tick();
      chk_bus("s1_c4", ent(B + 8)); chk_sr("s1_sr4", 1'b0); tick();
      chk_bus("s1_c5", EMPTY); chk_sr("s1_sr5", 1'b0);

      // word select with fixed SRAM data
      fixed_en = 1'b1;
      inst_sram_en = 1'b1; inst_sram_addr = B + 4; tick();
      inst_sram_addr = B; tick();
      inst_sram_en = 1'b0;
      chk_bus("ws_hi", {1'b1, B + 64'h4, 32'hAAAA_BBBB}); tick();
      chk_bus("ws_lo", {1'b1, B, 32'h1111_2222}); tick();
      chk_bus("ws_end", EMPTY);
      fixed_en = 1'b0;

      // replay drop
      inst_sram_en = 1'b1; inst_sram_addr = B + 64'h10; stall = 6'b000001;
      tick();
      chk_bus("rp_b", EMPTY); tick();
      stall = '0;
      chk_bus("rp_c", EMPTY); tick();
      inst_sram_en = 1'b0;
      chk_bus("rp_d", EMPTY); tick();
      chk_bus("rp_e", ent(B + 64'h10)); tick();
      chk_bus("rp_f", EMPTY);

      // decode backpressure, stall[1] for cycles 0..5
      for (int t = 0; t < 13; t++) begin
         bp_en[t] = (t <= 8); bp_s1[t] = (t <= 5);
         bp_s0[t] = (t >= 4 && t <= 6); bp_sr[t] = (t >= 4 && t <= 6);
         bp_addr[t] = '0; bp_head[t] = '0;
      end
      bp_addr[0] = B + 64'h100; bp_addr[1] = B + 64'h104; bp_addr[2] = B + 64'h108;
      bp_addr[3] = B + 64'h10C;
      for (int t = 4; t <= 7; t++) bp_addr[t] = B + 64'h110;
      bp_addr[8] = B + 64'h114;
      for (int t = 2; t <= 6; t++) bp_head[t] = B + 64'h100;
      bp_head[7] = B + 64'h104; bp_head[8] = B + 64'h108; bp_head[9] = B + 64'h10C;
      bp_head[10] = B + 64'h110; bp_head[11] = B + 64'h114;
      for (int t = 0; t < 13; t++) begin
         inst_sram_en = bp_en[t];
         inst_sram_addr = bp_en[t] ? bp_addr[t] : 64'h0;
         stall = {4'b0, bp_s1[t], bp_s0[t]};
         chk_bus($sformatf("bp_bus%0d", t), (bp_head[t] == 64'h0) ? EMPTY : ent(bp_head[t]));
         chk_sr($sformatf("bp_sr%0d", t), bp_sr[t]);
         tick();
      end
      stall = '0; inst_sram_en = 1'b0;

      // flush with 3 queued and 1 in flight
      stall = 6'b000010; inst_sram_en = 1'b1;
      inst_sram_addr = B + 64'h200; tick();
      inst_sram_addr = B + 64'h204; tick();
      inst_sram_addr = B + 64'h208; tick();
      inst_sram_addr = B + 64'h20C;
      chk_bus("fl_pre", ent(B + 64'h200)); chk_sr("fl_pre_sr", 1'b0); tick();
      chk_sr("fl_full_sr", 1'b1);
      flush = 1'b1; stall = 6'b000011; inst_sram_addr = B + 64'h210;
      #1;
      chk_vld("fl_vld", 1'b0);
      tick();
      flush = 1'b0; stall = '0; inst_sram_addr = B + 64'h400;
      chk_bus("fl_c5", EMPTY); chk_sr("fl_c5_sr", 1'b0); tick();
      inst_sram_en = 1'b0;
      chk_bus("fl_c6", EMPTY); chk_sr("fl_c6_sr", 1'b0); tick();
      chk_bus("fl_redir", ent(B + 64'h400)); tick();
      chk_bus("fl_end", EMPTY);

      // async reset with 2 queued
      stall = 6'b000010; inst_sram_en = 1'b1;
      inst_sram_addr = B + 64'h300; tick();
      inst_sram_addr = B + 64'h304; tick();
      inst_sram_en = 1'b0; tick();
      chk_bus("ar_pre", ent(B + 64'h300));
      #2 rst_n = 1'b0;
      #1;
      chk_bus("ar_bus", EMPTY); chk_sr("ar_sr", 1'b0);
      @(negedge clk) rst_n = 1'b1;
      stall = '0;
      tick();
      chk_bus("ar_post1", EMPTY); chk_sr("ar_post_sr", 1'b0); tick();
      chk_bus("ar_post2", EMPTY);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
